// File: rtl/axis_maxpool_raster.sv
// KxK stride-K max-pool over a raster-ordered AXI-Stream feature map.
// One accumulator per pooled column; output is a single skid-free register stage.
module axis_maxpool_raster #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned K      = 2,
    parameter int unsigned Win    = 28,
    parameter int unsigned Hin    = 28,
    parameter int unsigned N      = 6,
    parameter bit          SIGNED = 1'b0
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic [WIDTH-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tlast,
    output logic [WIDTH-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic             frame_err
);

    localparam int unsigned Wout   = Win / K;
    localparam int unsigned Hout   = Hin / K;
    localparam int unsigned ColLim = Wout * K;
    localparam int unsigned RowLim = Hout * K;
    localparam int unsigned ColW   = $clog2(Win);
    localparam int unsigned RowW   = $clog2(Hin);
    localparam int unsigned KW     = $clog2(K);
    localparam int unsigned OcW    = (Wout > 1) ? $clog2(Wout) : 1;
    localparam int unsigned ChW    = (N > 1) ? $clog2(N) : 1;

    logic [ColW-1:0]  col_q, col_d;
    logic [RowW-1:0]  row_q, row_d;
    logic [ChW-1:0]   ch_q, ch_d;
    logic [KW-1:0]    kc_q, kc_d;
    logic [KW-1:0]    kr_q, kr_d;
    logic [OcW-1:0]   oc_q, oc_d;
    logic [WIDTH-1:0] acc_q [Wout];

    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             last_q;
    logic             err_q;

    logic             in_xfer;
    logic             col_end, row_end, plane_end;
    logic             early_last, missing_last;
    logic             in_region, win_first, win_last, kc_last, kr_last;
    logic [WIDTH-1:0] pooled;

    function automatic logic [WIDTH-1:0] max_of(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        if (SIGNED) return ($signed(a) > $signed(b)) ? a : b;
        return (a > b) ? a : b;
    endfunction

    assign s_axis_tready = !areset && (!valid_q || m_axis_tready);
    assign in_xfer       = s_axis_tvalid && s_axis_tready;

    assign col_end      = 32'(col_q) == Win - 1;
    assign row_end      = 32'(row_q) == Hin - 1;
    assign plane_end    = col_end && row_end;
    assign early_last   = s_axis_tlast && !plane_end;
    assign missing_last = !s_axis_tlast && plane_end;

    assign kc_last   = 32'(kc_q) == K - 1;
    assign kr_last   = 32'(kr_q) == K - 1;
    assign in_region = (32'(col_q) < ColLim) && (32'(row_q) < RowLim);
    assign win_first = (kc_q == '0) && (kr_q == '0);
    assign win_last  = kc_last && kr_last;
    assign pooled    = max_of(acc_q[oc_q], s_axis_tdata);

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        ch_d  = ch_q;
        kc_d  = kc_q;
        kr_d  = kr_q;
        oc_d  = oc_q;
        if (in_xfer) begin
            if (early_last || col_end) begin
                col_d = '0;
                kc_d  = '0;
                oc_d  = '0;
            end else begin
                col_d = col_q + ColW'(1);
                kc_d  = kc_last ? '0 : kc_q + KW'(1);
                // oc parks on the last window so cropped columns never index past the array
                if (kc_last && (32'(oc_q) < Wout - 1)) oc_d = oc_q + OcW'(1);
            end
            if (early_last || plane_end) begin
                row_d = '0;
                kr_d  = '0;
                ch_d  = (32'(ch_q) == N - 1) ? '0 : ch_q + ChW'(1);
            end else if (col_end) begin
                row_d = row_q + RowW'(1);
                kr_d  = kr_last ? '0 : kr_q + KW'(1);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            col_q   <= '0;
            row_q   <= '0;
            ch_q    <= '0;
            kc_q    <= '0;
            kr_q    <= '0;
            oc_q    <= '0;
            for (int unsigned i = 0; i < Wout; i++) acc_q[i] <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            ch_q  <= ch_d;
            kc_q  <= kc_d;
            kr_q  <= kr_d;
            oc_q  <= oc_d;
            if (in_xfer && (early_last || missing_last)) err_q <= 1'b1;
            if (in_xfer && in_region) acc_q[oc_q] <= win_first ? s_axis_tdata : pooled;
            // Emit only happens on an input transfer, which implies the old word is gone
            if (in_xfer && in_region && win_last) begin
                data_q  <= pooled;
                valid_q <= 1'b1;
                last_q  <= (32'(oc_q) == Wout - 1) && (32'(row_q) == RowLim - 1);
            end else if (m_axis_tready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = data_q;
    assign m_axis_tvalid = valid_q;
    assign m_axis_tlast  = last_q;
    assign frame_err     = err_q;

endmodule

// File: doc/axis_maxpool_raster.md
Name: axis_maxpool_raster

Overview:
- Parametrised successor to the 2x2 AXI-Stream max-pool block.
- Accepts feature maps in plain raster order: pixel-by-pixel, row-by-row, one channel plane after another. The upstream no longer has to pre-arrange window samples.
- Supports KxK windows with stride K, signed or unsigned data, and multi-channel framing with TLAST.
- Sits between a conv/activation stage and the next layer on an AXI-Stream link.

Parameters:
- WIDTH, 8, data width in bits.
- K, 2, window size and stride (non-overlapping); legal range 2..8.
- Win, 28, input plane width in pixels; must be >= K.
- Hin, 28, input plane height in pixels; must be >= K.
- N, 6, channel planes per frame.
- SIGNED, 0, 1 = two's-complement compare, 0 = unsigned compare.
- Derived localparams: Wout = Win/K and Hout = Hin/K, both floor division.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  WIDTH  input pixel.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  high on the last pixel of each channel plane.
- m_axis_tdata  out  WIDTH  pooled pixel.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  high on the last pooled pixel of each plane.
- frame_err  out  1  sticky flag: input TLAST arrived misaligned with the counters.

Behaviour:
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, frame_err=0. All counters and accumulators are 0. s_axis_tready=0 while areset=1.
- Reset mid-operation: the next cycle after areset behaves as a fresh plane 0. Any pending output is dropped.
- Handshake: s_axis_tready = !m_axis_tvalid || m_axis_tready. A transfer occurs when valid && ready on either side.
- Output is a single register. m_axis_tdata, m_axis_tvalid and m_axis_tlast hold stable while valid && !ready.
- Counters advance only on an input transfer:
  - col 0..Win-1, wrapping to 0 and incrementing row.
  - row 0..Hin-1, wrapping to 0 and incrementing ch.
  - ch 0..N-1, wrapping to 0.
  - kc = col mod K and kr = row mod K are held as separate counters; no divider is used.
- Accumulator array: Wout entries of WIDTH bits, indexed oc = col/K (an incremental counter).
- Crop region: pixels with col >= Wout*K or row >= Hout*K are accepted but not accumulated and not emitted.
- Accumulate rule for an in-region pixel x:
  - If kr==0 and kc==0, acc[oc] <= x.
  - Otherwise acc[oc] <= max(acc[oc], x), signed or unsigned per SIGNED.
- Emit: when kr==K-1 and kc==K-1, in the same accepting cycle the output register loads max(acc[oc], x). m_axis_tvalid=1 on the next cycle (latency 1 from the last window pixel).
- Output TLAST: m_axis_tlast=1 exactly when the emitted pixel is (Hout-1, Wout-1) of the plane.
- Input TLAST check:
  - Expected on (row,col) = (Hin-1, Win-1).
  - Early s_axis_tlast: set frame_err, force counters to the start of the next plane, and discard any partial windows.
  - Expected position reached without s_axis_tlast: set frame_err and continue the normal wrap.
- frame_err is cleared only by areset.
- Simultaneous emit and output drain: a new emit may load in the same cycle the old word is accepted downstream. This gives full throughput of one input per cycle when m_axis_tready=1.
- Equal values: max returns the equal value, so no tie-break is needed.
- Output count: Wout*Hout*N words per frame, independent of N boundaries. Accumulator state never leaks across planes.

Test Plan:
- Basic 2x2: K=2, Win=Hin=4, N=1, input 0..15 raster, tlast on 15, m_axis_tready=1 -> outputs 5,7,13,15; tlast on 15 only; each output valid 1 cycle after its window closes.
- Signed compare: SIGNED=1, window {0xFF,0x01,0x80,0x00} -> output 0x01. Same window with SIGNED=0 -> output 0xFF.
- Crop and K=3: K=3, Win=Hin=7, N=2, input value = row*7+col -> 4 outputs per plane: 16,19,37,40. Row 6 and col 6 are ignored; tlast after the 4th and 8th outputs.
- Backpressure: 2x2 stream as in the basic test with m_axis_tready toggling 1,0,0,1 -> s_axis_tready deasserts while an output is stalled; no loss or duplication; sequence 5,7,13,15 intact.
- Framing error: s_axis_tlast asserted on pixel 10 of a 16-pixel plane -> frame_err=1 stays high. The next pixel is treated as (0,0) of the next plane, and a following correct 16-pixel plane yields the correct four outputs.
- Reset mid-plane: assert areset for 1 cycle after 6 input pixels -> all outputs 0 next cycle. A full fresh plane then produces 5,7,13,15.
